// File: rtl/irq_pkg.sv
// rtl/irq_pkg.sv - shared types and constants for the interrupt controller
package irq_pkg;

   typedef enum logic [1:0] {
      IRQ_IDLE    = 2'd0,
      IRQ_PRESENT = 2'd1,
      IRQ_SERVICE = 2'd2
   } irq_state_t;

   localparam logic ARB_FIXED = 1'b0;
   localparam logic ARB_RR    = 1'b1;

endpackage

// File: rtl/irq_arbiter.sv
// rtl/irq_arbiter.sv - combinational fixed / round-robin selector over an eligible vector
module irq_arbiter
   import irq_pkg::*;
#(
   parameter int NUM_IRQ = 8,
   parameter int ID_W    = $clog2(NUM_IRQ)
) (
   input  logic [NUM_IRQ-1:0] eligible,
   input  logic [ID_W-1:0]    last_id,
   input  logic               mode,
   output logic [ID_W-1:0]    sel_id,
   output logic               sel_valid
);

   localparam int SW = ID_W + 1;

   logic [SW-1:0]   start;
   logic            hi_found;
   logic            lo_found;
   logic [ID_W-1:0] hi_id;
   logic [ID_W-1:0] lo_id;

   // Round-robin is a search from start upward, falling back to the lowest
   // eligible index when nothing at or above start is eligible (the wrap).
   always_comb begin
      start    = '0;
      hi_found = 1'b0;
      lo_found = 1'b0;
      hi_id    = '0;
      lo_id    = '0;
      if (mode == ARB_RR && last_id != ID_W'(NUM_IRQ - 1)) begin
         start = {1'b0, last_id} + 1'b1;
      end
      for (int i = 0; i < NUM_IRQ; i++) begin
         if (eligible[i] && !lo_found) begin
            lo_found = 1'b1;
            lo_id    = ID_W'(i);
         end
         if (eligible[i] && !hi_found && (SW'(i) >= start)) begin
            hi_found = 1'b1;
            hi_id    = ID_W'(i);
         end
      end
      sel_valid = lo_found;
      sel_id    = hi_found ? hi_id : lo_id;
   end

endmodule

// File: rtl/interrupt_controller.sv
// rtl/interrupt_controller.sv - pending/mask registers and present/service handshake FSM
module interrupt_controller
   import irq_pkg::*;
#(
   parameter int                   NUM_IRQ  = 8,
   parameter int                   ID_W     = $clog2(NUM_IRQ),
   parameter logic [NUM_IRQ-1:0]   EDGE_SEL = {NUM_IRQ{1'b1}}
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic [NUM_IRQ-1:0] irq_in,
   input  logic               mask_we,
   input  logic [NUM_IRQ-1:0] mask_wdata,
   input  logic               rr_mode,
   input  logic               irq_ack,
   input  logic               irq_eoi,
   output logic               irq_valid,
   output logic [ID_W-1:0]    irq_id,
   output logic               busy,
   output logic [NUM_IRQ-1:0] pending
);

   localparam logic [NUM_IRQ-1:0] ONE_HOT0 = NUM_IRQ'(1);

   irq_state_t         state_q;
   irq_state_t         state_d;
   logic [NUM_IRQ-1:0] irq_q;
   logic [NUM_IRQ-1:0] pend_edge_q;
   logic [NUM_IRQ-1:0] mask_q;
   logic [ID_W-1:0]    last_id_q;
   logic [NUM_IRQ-1:0] eligible;
   logic [NUM_IRQ-1:0] set_vec;
   logic [NUM_IRQ-1:0] clr_vec;
   logic [ID_W-1:0]    sel_id;
   logic               sel_valid;
   logic               ack_fire;
   logic               load_sel;

   // Level sources are never stored: their pending bit is the live line.
   assign pending  = (pend_edge_q & EDGE_SEL) | (irq_in & ~EDGE_SEL);
   assign eligible = pending & ~mask_q;

   irq_arbiter #(
      .NUM_IRQ (NUM_IRQ),
      .ID_W    (ID_W)
   ) u_arbiter (
      .eligible  (eligible),
      .last_id   (last_id_q),
      .mode      (rr_mode),
      .sel_id    (sel_id),
      .sel_valid (sel_valid)
   );

   assign ack_fire = (state_q == IRQ_PRESENT) && irq_ack;
   assign load_sel = (state_q == IRQ_IDLE) && sel_valid;

   // Set is applied after clear so a new edge in the ack cycle survives.
   assign set_vec = irq_in & ~irq_q & EDGE_SEL;
   assign clr_vec = ack_fire ? ((ONE_HOT0 << irq_id) & EDGE_SEL) : '0;

   always_comb begin
      state_d = state_q;
      case (state_q)
         IRQ_IDLE:    if (sel_valid) state_d = IRQ_PRESENT;
         IRQ_PRESENT: if (irq_ack)   state_d = IRQ_SERVICE;
         IRQ_SERVICE: if (irq_eoi)   state_d = IRQ_IDLE;
         default:                    state_d = IRQ_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IRQ_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         irq_q       <= '0;
         pend_edge_q <= '0;
         mask_q      <= '1;
         last_id_q   <= ID_W'(NUM_IRQ - 1);
         irq_id      <= '0;
      end else begin
         irq_q       <= irq_in;
         pend_edge_q <= (pend_edge_q & ~clr_vec) | set_vec;
         if (mask_we) begin
            mask_q <= mask_wdata;
         end
         if (load_sel) begin
            irq_id <= sel_id;
         end
         if (ack_fire) begin
            last_id_q <= irq_id;
         end
      end
   end

   assign irq_valid = (state_q == IRQ_PRESENT);
   assign busy      = (state_q == IRQ_SERVICE);

endmodule

// File: tb/tb_interrupt_controller.sv
// tb/tb_interrupt_controller.sv - directed and randomized checks against a behavioural model
module tb_interrupt_controller;

   localparam int         N  = 8;
   localparam int         IW = 3;
   localparam logic [7:0] ES = 8'b1011_1101;

   logic          clk        = 1'b0;
   logic          rst_n      = 1'b0;
   logic [N-1:0]  irq_in     = '0;
   logic          mask_we    = 1'b0;
   logic [N-1:0]  mask_wdata = '0;
   logic          rr_mode    = 1'b0;
   logic          irq_ack    = 1'b0;
   logic          irq_eoi    = 1'b0;
   logic          irq_valid;
   logic [IW-1:0] irq_id;
   logic          busy;
   logic [N-1:0]  pending;

   int n_checks = 0;
   int n_errors = 0;

   interrupt_controller #(
      .NUM_IRQ  (N),
      .ID_W     (IW),
      .EDGE_SEL (ES)
   ) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .irq_in     (irq_in),
      .mask_we    (mask_we),
      .mask_wdata (mask_wdata),
      .rr_mode    (rr_mode),
      .irq_ack    (irq_ack),
      .irq_eoi    (irq_eoi),
      .irq_valid  (irq_valid),
      .irq_id     (irq_id),
      .busy       (busy),
      .pending    (pending)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model: edge-pending bits, mask, and whether an interrupt is
   // being presented or serviced.
   logic [N-1:0] m_edge = '0;
   logic [N-1:0] m_mask = '1;
   logic [N-1:0] m_prev = '0;
   bit           m_pres = 1'b0;
   bit           m_serv = 1'b0;
   int           m_id   = 0;
   int           m_last = N - 1;
   logic [N-1:0] m_elig;
   logic [N-1:0] m_new;
   int           m_pick;

   function automatic int pick(input logic [N-1:0] e, input logic rr, input int last);
      if (rr) begin
         for (int k = 1; k <= N; k++) begin
            int idx;
            idx = (last + k) % N;
            if (e[idx]) return idx;
         end
      end else begin
         for (int i = 0; i < N; i++) begin
            if (e[i]) return i;
         end
      end
      return -1;
   endfunction

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_edge = '0;
         m_mask = '1;
         m_prev = '0;
         m_pres = 1'b0;
         m_serv = 1'b0;
         m_id   = 0;
         m_last = N - 1;
      end else begin
         m_elig = (m_edge | (irq_in & ~ES)) & ~m_mask;
         m_pick = pick(m_elig, rr_mode, m_last);
         m_new  = irq_in & ~m_prev & ES;
         if (m_pres) begin
            if (irq_ack) begin
               m_pres       = 1'b0;
               m_serv       = 1'b1;
               m_last       = m_id;
               m_edge[m_id] = 1'b0;
            end
         end else if (m_serv) begin
            if (irq_eoi) m_serv = 1'b0;
         end else if (m_pick >= 0) begin
            m_pres = 1'b1;
            m_id   = m_pick;
         end
         m_edge = m_edge | m_new;
         if (mask_we) m_mask = mask_wdata;
         m_prev = irq_in;
      end
   end

   always @(negedge clk) begin
      chk("model valid", {31'd0, irq_valid}, {31'd0, m_pres});
      chk("model busy", {31'd0, busy}, {31'd0, m_serv});
      chk("model pending", {24'd0, pending}, {24'd0, m_edge | (irq_in & ~ES)});
      if (m_pres || m_serv) chk("model id", {29'd0, irq_id}, m_id);
   end

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic wait_valid(input int maxc, input string nm);
      int n;
      n = 0;
      while (!irq_valid && n < maxc) begin
         tick(1);
         n++;
      end
      chk({nm, " wait valid"}, {31'd0, irq_valid}, 32'd1);
   endtask

   task automatic service(input int exp_id, input string nm);
      wait_valid(50, nm);
      chk({nm, " id"}, {29'd0, irq_id}, exp_id);
      irq_ack = 1'b1;
      tick(1);
      irq_ack = 1'b0;
      chk({nm, " busy after ack"}, {31'd0, busy}, 32'd1);
      chk({nm, " valid after ack"}, {31'd0, irq_valid}, 32'd0);
      tick(2);
      irq_eoi = 1'b1;
      tick(1);
      irq_eoi = 1'b0;
      chk({nm, " busy after eoi"}, {31'd0, busy}, 32'd0);
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      tick(3);
      rst_n = 1'b1;
      tick(1);
   endtask

   initial begin
      // Reset values and a masked edge pulse
      tick(3);
      rst_n = 1'b1;
      @(negedge clk); #1;
      chk("rst valid", {31'd0, irq_valid}, 32'd0);
      chk("rst busy", {31'd0, busy}, 32'd0);
      chk("rst id", {29'd0, irq_id}, 32'd0);
      chk("rst pending", {24'd0, pending}, 32'd0);
      tick(1);
      irq_in = 8'h08;
      tick(1);
      irq_in = 8'h00;
      chk("masked pulse pending", {24'd0, pending}, 32'h08);
      tick(4);
      chk("masked pulse no valid", {31'd0, irq_valid}, 32'd0);
      chk("masked pulse held", {24'd0, pending}, 32'h08);

      // Fixed priority: 2, 3, 5
      irq_in     = 8'b0010_1100;
      mask_we    = 1'b1;
      mask_wdata = 8'h00;
      tick(1);
      mask_we = 1'b0;
      chk("fixed pending", {24'd0, pending}, 32'h2C);
      chk("fixed valid early", {31'd0, irq_valid}, 32'd0);
      tick(1);
      chk("fixed valid latency", {31'd0, irq_valid}, 32'd1);
      chk("fixed first id", {29'd0, irq_id}, 32'd2);
      irq_in = 8'h00;
      service(2, "fixed a");
      service(3, "fixed b");
      service(5, "fixed c");
      tick(3);
      chk("fixed drained", {31'd0, irq_valid}, 32'd0);

      // No preemption by a higher source or a mask write while presenting
      irq_in = 8'h10;
      wait_valid(10, "hold");
      chk("hold id", {29'd0, irq_id}, 32'd4);
      irq_in     = 8'h11;
      mask_we    = 1'b1;
      mask_wdata = 8'hFF;
      tick(1);
      mask_we = 1'b0;
      tick(2);
      chk("hold still valid", {31'd0, irq_valid}, 32'd1);
      chk("hold still id", {29'd0, irq_id}, 32'd4);
      mask_we    = 1'b1;
      mask_wdata = 8'h00;
      tick(1);
      mask_we = 1'b0;
      service(4, "hold a");
      service(0, "hold b");
      irq_in = 8'h00;
      tick(2);

      // Ack collides with a new rising edge on the same source
      irq_in = 8'h04;
      tick(1);
      irq_in = 8'h00;
      wait_valid(10, "collide");
      chk("collide id", {29'd0, irq_id}, 32'd2);
      irq_ack = 1'b1;
      irq_in  = 8'h04;
      tick(1);
      irq_ack = 1'b0;
      chk("collide pending bit", {31'd0, pending[2]}, 32'd1);
      chk("collide busy", {31'd0, busy}, 32'd1);
      tick(1);
      irq_eoi = 1'b1;
      tick(1);
      irq_eoi = 1'b0;
      irq_in  = 8'h00;
      service(2, "collide again");
      tick(2);

      // Asynchronous reset while servicing
      irq_in = 8'hA0;
      wait_valid(10, "arst");
      chk("arst id", {29'd0, irq_id}, 32'd5);
      irq_ack = 1'b1;
      tick(1);
      irq_ack = 1'b0;
      irq_in  = 8'h00;
      chk("arst busy before", {31'd0, busy}, 32'd1);
      chk("arst pending before", {24'd0, pending}, 32'h80);
      #2;
      rst_n = 1'b0;
      #1;
      chk("arst busy", {31'd0, busy}, 32'd0);
      chk("arst valid", {31'd0, irq_valid}, 32'd0);
      chk("arst pending", {24'd0, pending}, 32'd0);
      tick(2);
      rst_n = 1'b1;
      tick(1);

      // Round-robin among two level sources
      mask_we    = 1'b1;
      mask_wdata = 8'h00;
      tick(1);
      mask_we = 1'b0;
      rr_mode = 1'b1;
      irq_in  = 8'h42;
      service(1, "rr a");
      service(6, "rr b");
      service(1, "rr c");
      service(6, "rr d");
      irq_in  = 8'h00;
      rr_mode = 1'b0;
      tick(2);

      // Randomized traffic checked every cycle by the model
      do_reset();
      for (int i = 0; i < 3000; i++) begin
         for (int b = 0; b < N; b++) begin
            if ($urandom_range(0, 9) == 0) irq_in[b] = ~irq_in[b];
         end
         mask_we    = ($urandom_range(0, 19) == 0);
         mask_wdata = N'($urandom & $urandom);
         rr_mode    = 1'($urandom_range(0, 1));
         irq_ack    = ($urandom_range(0, 2) == 0);
         irq_eoi    = ($urandom_range(0, 2) == 0);
         if (i == 1500) begin
            #2;
            rst_n = 1'b0;
            #4;
            rst_n = 1'b1;
         end
         tick(1);
      end
      irq_ack = 1'b0;
      irq_eoi = 1'b0;
      tick(2);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/interrupt_controller.md
# interrupt_controller

Parametrised, registered successor to the 4-input combinational priority encoder: collects `NUM_IRQ` interrupt sources, latches edge-type events as pending, applies a software mask, and selects one source by fixed (lowest index wins) or round-robin priority. The chosen ID is presented to the core through a valid/ack handshake and held in service until an end-of-interrupt (EOI) pulse. It sits between peripheral interrupt lines and the CPU trap logic.

## Interface
- `NUM_IRQ`, 8: number of sources, 2..32
- `ID_W`, `$clog2(NUM_IRQ)`: ID width
- `EDGE_SEL`, `{NUM_IRQ{1'b1}}`: per-source type; 1 = rising-edge (latched), 0 = level
- `clk`  in  1  single clock, all logic on rising edge
- `rst_n`  in  1  asynchronous, active-low reset
- `irq_in`  in  NUM_IRQ  raw source lines, synchronous to `clk`
- `mask_we`  in  1  load mask register
- `mask_wdata`  in  NUM_IRQ  new mask; 1 = source disabled
- `rr_mode`  in  1  0 = fixed priority, 1 = round-robin
- `irq_ack`  in  1  core accepts presented interrupt
- `irq_eoi`  in  1  core finished servicing active interrupt
- `irq_valid`  out  1  interrupt presented
- `irq_id`  out  ID_W  presented/active source ID
- `busy`  out  1  interrupt in service
- `pending`  out  NUM_IRQ  current pending vector (unmasked view)

## Operation
- Pending: edge sources set on `irq_in & ~irq_q`; cleared only by ack of that ID. Level sources mirror `irq_in` live, never latched.
- Eligible = `pending & ~mask`.
- Fixed mode: lowest eligible index. Round-robin: first eligible index searching upward from `last_id+1`, wrapping at `NUM_IRQ-1` to 0; `last_id` updates on every ack.
- FSM states IDLE, PRESENT, SERVICE:
  - IDLE: if any eligible -> PRESENT, register selected ID into `irq_id`, `irq_valid`=1.
  - PRESENT: `irq_id` frozen; no preemption by newer/higher sources, mask writes, or level withdrawal. `irq_ack` -> SERVICE, `irq_valid`=0, `busy`=1, clear pending bit of `irq_id` if edge type.
  - SERVICE: `irq_id` holds active ID. `irq_eoi` -> IDLE, `busy`=0.
- `irq_ack` outside PRESENT and `irq_eoi` outside SERVICE ignored.

## Timing
- Reset values: `irq_valid`=0, `irq_id`=0, `busy`=0, `pending`=0, mask = all ones (all disabled), `irq_q`=0, `last_id`=`NUM_IRQ-1` (first RR search starts at 0), state IDLE.
- Edge source low at edge k-1, high at edge k -> pending bit visible after edge k -> `irq_valid`/`irq_id` after edge k+1 (2-cycle latency). Level source: 1-cycle latency.
- Ack at edge a -> `irq_valid`=0, `busy`=1 after edge a. EOI at edge e -> `busy`=0 after e; earliest next `irq_valid` after e+1.
- Same-cycle new edge on the ID being cleared by ack: set wins, bit stays pending.
- Mask write takes effect for selection from the next cycle; never alters a presented or active ID.
- `rr_mode` sampled combinationally at IDLE selection only.
- `rst_n` low mid-PRESENT or mid-SERVICE: immediate return to reset values; no event retained.
- `irq_id` width arithmetic: RR index computed modulo `NUM_IRQ` (non-power-of-two supported).

## Structure
- Package `irq_pkg`: FSM state enum (`IRQ_IDLE`, `IRQ_PRESENT`, `IRQ_SERVICE`), mode constants `ARB_FIXED`/`ARB_RR`.
- One combinational sub-module `irq_arbiter` (eligible vector, `last_id`, mode -> `sel_id`, `sel_valid`); reusable elsewhere. Pending/mask registers and FSM stay in top.

## Test plan
- Reset: after `rst_n` release, all outputs 0, mask all ones; pulse `irq_in[3]` -> `pending`=8'h08, `irq_valid` stays 0.
- Fixed: mask=0, `irq_in`=8'b0010_1100 rising together -> `irq_id`=2 two cycles later; ack/EOI loops give IDs 2, 3, 5, then `irq_valid`=0.
- Round-robin: `rr_mode`=1, sources 1 and 6 as levels held high -> successive presents 1, 6, 1, 6.
- Hold/no-preempt: present ID 4, then raise source 0 -> `irq_id` stays 4 until ack; after EOI next `irq_id`=0.
- Ack collision: ack ID 2 in same cycle as new rising edge on source 2 -> `pending[2]` remains 1, re-presented after EOI.
- Reset mid-SERVICE: `busy`=1, assert `rst_n`=0 asynchronously -> `busy`, `irq_valid`, `pending` 0 before next clock edge.
